// File: rtl/mult_pkg.sv
// Shared definitions for the 8x8 sequential shift-add multiplier.
// Optional feature: MULT_EARLY_TERM_EN (stop iterating once the remaining
// multiplier bits are all zero).
package mult_pkg;

    localparam int OP_W   = 8;
    localparam int RES_W  = 16;
    localparam int ITERS  = 8;
    localparam int CNT_W  = $clog2(ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when the iteration being performed this cycle is the last one.
    function automatic logic is_last_iter(input logic [CNT_W-1:0] cnt,
                                          input logic [OP_W-1:0]  mp);
        logic last;
        last = (cnt == CNT_W'(ITERS - 1));
`ifdef MULT_EARLY_TERM_EN
        // After this shift the multiplier is empty, so further adds are no-ops.
        last = last || (mp[OP_W-1:1] == '0);
`else
        if (mp == '1) begin
            last = last;
        end
`endif
        return last;
    endfunction

endpackage

// File: rtl/adder_16bit.sv
// 16-bit ripple adder with carry in/out, shared datapath building block.
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);

    // Full 17-bit sum so the carry-out falls out of the top bit.
    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
    end

endmodule

// File: rtl/multiplier_8x8_seq.sv
// 8x8 unsigned sequential shift-add multiplier, one partial product per cycle.
// Optional feature: MULT_EARLY_TERM_EN ends the BUSY phase as soon as the
// remaining multiplier bits are zero; the product is identical either way.
module multiplier_8x8_seq
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] product
);

    state_t             state;
    state_t             state_next;
    logic [RES_W-1:0]   acc;
    logic [RES_W-1:0]   mcand;
    logic [RES_W-1:0]   sum;
    logic [RES_W-1:0]   acc_next;
    logic [OP_W-1:0]    mplier;
    logic [CNT_W-1:0]   count;
    logic               last_iter;

    // The only datapath adder; carry-out cannot occur since 255*255 fits.
    adder_16bit u_adder (
        .a    (acc),
        .b    (mcand),
        .cin  (1'b0),
        .s    (sum),
        .cout ()
    );

    // Accumulator value after this cycle's conditional add, and end-of-run test.
    always_comb begin
        acc_next  = mplier[0] ? sum : acc;
        last_iter = is_last_iter(count, mplier);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs; start only matters in IDLE.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, shift-add iterations and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{(RES_W-OP_W){1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (last_iter) begin
                        product <= acc_next;
                    end
                end
                default: begin
                    acc <= acc;
                end
            endcase
        end
    end

endmodule
